// File: rtl/div_unit_if.sv
// Operand/result bundle between the EX-stage issue logic and the iterative divider.
// master drives the request; slave is the divider and returns result, strobe and busy.
interface div_unit_if #(parameter int WIDTH = 32);
  logic                 start_i;
  logic                 signed_i;
  logic                 annul_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;

  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, dividend_i, divisor_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider giving {remainder, quotient}; WIDTH+1 cycles from accept to ready strobe.
// busy_o stalls the pipeline while iterating; annul_i aborts without a strobe.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   rem_q;
  logic [WIDTH-1:0]   dvs;
  logic               neg_a;
  logic               neg_b;

  logic [2*WIDTH:0]   sh;
  logic [2*WIDTH:0]   rem_nx;
  logic [WIDTH+1:0]   diff;
  logic               take;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;

  always_comb begin
    a_mag  = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? -bus.dividend_i : bus.dividend_i;
    b_mag  = (bus.signed_i && bus.divisor_i[WIDTH-1])  ? -bus.divisor_i  : bus.divisor_i;
    sh     = rem_q << 1;
    // Extra guard bit so the sign of the trial subtraction is unambiguous.
    diff   = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, dvs};
    take   = ~diff[WIDTH+1];
    rem_nx = {take ? diff[WIDTH:0] : sh[2*WIDTH:WIDTH],
              sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, take}};
    q_fin  = rem_nx[WIDTH-1:0];
    r_fin  = rem_nx[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FREE;
      cnt          <= '0;
      rem_q        <= '0;
      dvs          <= '0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
      bus.busy_o   <= 1'b0;
    end else begin
      bus.ready_o <= 1'b0;
      case (state)
        FREE: begin
          if (bus.start_i && !bus.annul_i) begin
            neg_a      <= bus.signed_i & bus.dividend_i[WIDTH-1];
            neg_b      <= bus.signed_i & bus.divisor_i[WIDTH-1];
            rem_q      <= {{(WIDTH+1){1'b0}}, a_mag};
            dvs        <= b_mag;
            cnt        <= '0;
            bus.busy_o <= 1'b1;
            state      <= (bus.divisor_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          bus.busy_o <= 1'b0;
          if (bus.annul_i) begin
            state <= FREE;
          end else begin
            state        <= END;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            state      <= FREE;
            bus.busy_o <= 1'b0;
          end else begin
            rem_q <= rem_nx;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH-1)) begin
              state        <= END;
              bus.busy_o   <= 1'b0;
              bus.ready_o  <= 1'b1;
              // Remainder follows the dividend's sign; -MIN/-1 wraps naturally.
              bus.result_o <= {neg_a ? -r_fin : r_fin,
                               (neg_a ^ neg_b) ? -q_fin : q_fin};
            end
          end
        end
        END:     state <= FREE;
        default: state <= FREE;
      endcase
    end
  end
endmodule
